// File: rtl/ans_pkg.sv
// Shared types and defaults for the streaming rANS decoder.
package ans_pkg;

    localparam int unsigned ANS_SYM_WIDTH   = 4;
    localparam int unsigned ANS_SYM_COUNT   = 16;
    localparam int unsigned ANS_PROB_BITS   = 8;
    localparam int unsigned ANS_STATE_WIDTH = 16;
    localparam int unsigned ANS_IN_WIDTH    = 4;
    localparam int unsigned ANS_LEN_WIDTH   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DECODE = 3'd2,
        EMIT   = 3'd3,
        RENORM = 3'd4
    } dec_state_e;

    // Bit position of L = 2^(STATE_WIDTH-IN_WIDTH); x < L iff bits at and above it are zero.
    function automatic int unsigned l_bound_shift(input int unsigned state_width,
                                                  input int unsigned in_width);
        return state_width - in_width;
    endfunction

endpackage

// File: rtl/ans_sym_lookup.sv
// Combinational prefix-sum and slot search over the frequency table.
module ans_sym_lookup
    import ans_pkg::*;
#(
    parameter int unsigned SYM_WIDTH = ANS_SYM_WIDTH,
    parameter int unsigned SYM_COUNT = ANS_SYM_COUNT,
    parameter int unsigned PROB_BITS = ANS_PROB_BITS,
    parameter int unsigned CNT_WIDTH = PROB_BITS + 1
) (
    input  logic [CNT_WIDTH*SYM_COUNT-1:0] counts_unpacked,
    input  logic [PROB_BITS-1:0]           slot,
    output logic [SYM_WIDTH-1:0]           sym,
    output logic [CNT_WIDTH-1:0]           freq,
    output logic [CNT_WIDTH-1:0]           cum,
    output logic                           sum_ok
);

    localparam int unsigned SUM_W = CNT_WIDTH + $clog2(SYM_COUNT + 1);

    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] f_ext;
    logic [SUM_W-1:0] slot_ext;
    logic             found;

    always_comb begin
        acc      = '0;
        f_ext    = '0;
        slot_ext = SUM_W'(slot);
        found    = 1'b0;
        sym      = '0;
        freq     = '0;
        cum      = '0;
        // Zero-frequency entries have an empty interval and can never match.
        for (int unsigned i = 0; i < SYM_COUNT; i++) begin
            f_ext = SUM_W'(counts_unpacked[i*CNT_WIDTH +: CNT_WIDTH]);
            if (!found && (f_ext != '0) && (slot_ext >= acc) && (slot_ext < acc + f_ext)) begin
                found = 1'b1;
                sym   = SYM_WIDTH'(i);
                freq  = counts_unpacked[i*CNT_WIDTH +: CNT_WIDTH];
                cum   = CNT_WIDTH'(acc);
            end
            acc = acc + f_ext;
        end
        sum_ok = (acc == SUM_W'(1 << PROB_BITS));
    end

endmodule

// File: rtl/ans_rans_decoder.sv
// Streaming rANS decoder: loads state, decodes num_syms symbols, renormalises on demand.
module ans_rans_decoder
    import ans_pkg::*;
#(
    parameter int unsigned SYM_WIDTH   = ANS_SYM_WIDTH,
    parameter int unsigned SYM_COUNT   = ANS_SYM_COUNT,
    parameter int unsigned PROB_BITS   = ANS_PROB_BITS,
    parameter int unsigned CNT_WIDTH   = PROB_BITS + 1,
    parameter int unsigned STATE_WIDTH = ANS_STATE_WIDTH,
    parameter int unsigned IN_WIDTH    = ANS_IN_WIDTH,
    parameter int unsigned LEN_WIDTH   = ANS_LEN_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           start,
    input  logic [LEN_WIDTH-1:0]           num_syms,
    input  logic [CNT_WIDTH*SYM_COUNT-1:0] counts_unpacked,
    input  logic [IN_WIDTH-1:0]            in,
    input  logic                           in_vld,
    output logic                           in_rdy,
    output logic [SYM_WIDTH-1:0]           out,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int unsigned WORDS   = STATE_WIDTH / IN_WIDTH;
    localparam int unsigned LC_W    = $clog2(WORDS + 1);
    localparam int unsigned L_SHIFT = l_bound_shift(STATE_WIDTH, IN_WIDTH);
    localparam int unsigned PW      = CNT_WIDTH + STATE_WIDTH;

    dec_state_e             state_q, state_d;
    logic [STATE_WIDTH-1:0] x_q, x_d;
    logic [LEN_WIDTH-1:0]   rem_q, rem_d;
    logic [LC_W-1:0]        cnt_q, cnt_d;
    logic [SYM_WIDTH-1:0]   out_q, out_d;
    logic                   out_vld_q, out_vld_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [SYM_WIDTH-1:0]   lk_sym;
    logic [CNT_WIDTH-1:0]   lk_freq;
    logic [CNT_WIDTH-1:0]   lk_cum;
    logic                   lk_sum_ok;
    logic [STATE_WIDTH-1:0] x_shift;
    logic [STATE_WIDTH-1:0] x_dec;

    ans_sym_lookup #(
        .SYM_WIDTH (SYM_WIDTH),
        .SYM_COUNT (SYM_COUNT),
        .PROB_BITS (PROB_BITS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_lookup (
        .counts_unpacked (counts_unpacked),
        .slot            (x_q[PROB_BITS-1:0]),
        .sym             (lk_sym),
        .freq            (lk_freq),
        .cum             (lk_cum),
        .sum_ok          (lk_sum_ok)
    );

    assign x_shift = {x_q[STATE_WIDTH-IN_WIDTH-1:0], in};
    assign x_dec   = STATE_WIDTH'(PW'(lk_freq) * PW'(x_q >> PROB_BITS)
                                  + PW'(x_q[PROB_BITS-1:0]) - PW'(lk_cum));

    assign in_rdy  = (state_q == LOAD) || (state_q == RENORM);
    assign busy    = (state_q != IDLE);
    assign out     = out_q;
    assign out_vld = out_vld_q;
    assign done    = done_q;
    assign err     = err_q;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        out_vld_d = out_vld_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!lk_sum_ok) begin
                        err_d = 1'b1;
                    end else if (num_syms == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = num_syms;
                        cnt_d   = '0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (in_vld) begin
                    x_d   = x_shift;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LC_W'(WORDS - 1)) state_d = DECODE;
                end
            end
            DECODE: begin
                out_d     = lk_sym;
                out_vld_d = 1'b1;
                x_d       = x_dec;
                rem_d     = rem_q - 1'b1;
                state_d   = EMIT;
            end
            EMIT: begin
                if (out_rdy) begin
                    out_vld_d = 1'b0;
                    if (rem_q == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (x_q[STATE_WIDTH-1:L_SHIFT] == '0) begin
                        state_d = RENORM;
                    end else begin
                        state_d = DECODE;
                    end
                end
            end
            RENORM: begin
                if (in_vld) begin
                    x_d = x_shift;
                    if (x_shift[STATE_WIDTH-1:L_SHIFT] != '0) state_d = DECODE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // en gates every register update, so handshakes cannot complete while it is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (en) begin
            state_q   <= state_d;
            x_q       <= x_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_ans_rans_decoder.sv
// Scoreboard bench for ans_rans_decoder: directed streams, expected symbols queued at issue.
module tb_ans_rans_decoder;

    localparam int unsigned SW  = 4;
    localparam int unsigned SC  = 16;
    localparam int unsigned PB  = 8;
    localparam int unsigned CW  = 9;
    localparam int unsigned STW = 16;
    localparam int unsigned IW  = 4;
    localparam int unsigned LW  = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             start;
    logic [LW-1:0]    num_syms;
    logic [CW*SC-1:0] counts;
    logic [IW-1:0]    in_w;
    logic             in_vld;
    logic             in_rdy;
    logic [SW-1:0]    out_w;
    logic             out_vld;
    logic             out_rdy;
    logic             busy;
    logic             done;
    logic             err;

    always #5 clk = ~clk;

    ans_rans_decoder #(
        .SYM_WIDTH   (SW),
        .SYM_COUNT   (SC),
        .PROB_BITS   (PB),
        .CNT_WIDTH   (CW),
        .STATE_WIDTH (STW),
        .IN_WIDTH    (IW),
        .LEN_WIDTH   (LW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .start           (start),
        .num_syms        (num_syms),
        .counts_unpacked (counts),
        .in              (in_w),
        .in_vld          (in_vld),
        .in_rdy          (in_rdy),
        .out             (out_w),
        .out_vld         (out_vld),
        .out_rdy         (out_rdy),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    int errors   = 0;
    int checks   = 0;
    int consumed = 0;
    int done_cnt = 0;
    int viol     = 0;
    logic          in_pend;
    logic [IW-1:0] in_q[$];
    logic [SW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Input driver: presents the head of in_q, pops on a completed transfer.
    initial begin
        in_vld  = 1'b0;
        in_w    = '0;
        in_pend = 1'b0;
        forever begin
            @(negedge clk);
            in_pend = in_vld && in_rdy && en && rst_n;
            @(posedge clk);
            if (in_pend && rst_n && in_q.size() > 0) begin
                void'(in_q.pop_front());
                consumed++;
            end
            #1;
            if (in_q.size() > 0) begin
                in_vld = 1'b1;
                in_w   = in_q[0];
            end else begin
                in_vld = 1'b0;
            end
        end
    end

    // Monitor: compares every output transfer against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) done_cnt++;
                if ((in_rdy && out_vld) || (in_rdy && !busy)) viol++;
                if (out_vld && out_rdy && en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sym_unexpected: got %0h expected none", out_w);
                    end else begin
                        check("sym", 32'(out_w), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic set_uniform();
        for (int i = 0; i < SC; i++) counts[i*CW +: CW] = 9'd16;
    endtask

    task automatic do_start(input logic [LW-1:0] n);
        @(posedge clk);
        #1;
        num_syms = n;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((busy || exp_q.size() > 0) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        #1;
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic push_vec1();
        in_q.push_back(4'h1);
        in_q.push_back(4'h2);
        in_q.push_back(4'h3);
        in_q.push_back(4'h4);
        in_q.push_back(4'hA);
        in_q.push_back(4'h7);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd4);
    endtask

    task automatic vec1(input string tag);
        int c0, d0;
        set_uniform();
        c0 = consumed;
        d0 = done_cnt;
        push_vec1();
        do_start(16'd2);
        wait_idle(tag);
        check({tag, "_consumed"}, consumed - c0, 5);
        check({tag, "_left"}, in_q.size(), 1);
        check({tag, "_done"}, done_cnt - d0, 1);
        in_q.delete();
    endtask

    initial begin
        int c0, d0, k;
        rst_n    = 1'b0;
        en       = 1'b1;
        start    = 1'b0;
        num_syms = '0;
        out_rdy  = 1'b1;
        counts   = '0;
        set_uniform();
        #12;
        check("rst_in_rdy", 32'(in_rdy), 0);
        check("rst_out_vld", 32'(out_vld), 0);
        check("rst_out", 32'(out_w), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;

        // Uniform table with output backpressure on the first symbol.
        c0 = consumed;
        d0 = done_cnt;
        out_rdy = 1'b0;
        push_vec1();
        do_start(16'd2);
        k = 0;
        while (!out_vld && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("bp_vld", 32'(out_vld), 1);
        check("bp_loaded", consumed - c0, 4);
        repeat (5) begin
            @(negedge clk);
            check("bp_out", 32'(out_w), 3);
            check("bp_vld_hold", 32'(out_vld), 1);
            check("bp_in_rdy", 32'(in_rdy), 0);
        end
        @(posedge clk);
        #1 out_rdy = 1'b1;
        wait_idle("v1");
        check("v1_consumed", consumed - c0, 5);
        check("v1_left", in_q.size(), 1);
        check("v1_done", done_cnt - d0, 1);
        in_q.delete();

        // Single-symbol table: x stays at 0x1000 >= L, so no renormalisation.
        counts = '0;
        counts[5*CW +: CW] = 9'd256;
        c0 = consumed;
        d0 = done_cnt;
        in_q.push_back(4'h1);
        in_q.push_back(4'h0);
        in_q.push_back(4'h0);
        in_q.push_back(4'h0);
        in_q.push_back(4'hF);
        repeat (3) exp_q.push_back(4'd5);
        do_start(16'd3);
        wait_idle("v2");
        check("v2_consumed", consumed - c0, 4);
        check("v2_done", done_cnt - d0, 1);
        check("v2_in_rdy", 32'(in_rdy), 0);
        in_q.delete();

        // en low mid-LOAD holds everything.
        set_uniform();
        c0 = consumed;
        push_vec1();
        do_start(16'd2);
        k = 0;
        while (consumed - c0 < 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 en = 1'b0;
        #1 d0 = consumed;
        repeat (4) begin
            @(negedge clk);
            check("en_hold_consumed", consumed, d0);
            check("en_hold_in_rdy", 32'(in_rdy), 1);
        end
        @(posedge clk);
        #1 en = 1'b1;
        wait_idle("en");
        check("en_consumed", consumed - c0, 5);
        in_q.delete();

        // Bad table is rejected; zero-length block completes immediately.
        counts[0 +: CW] = 9'd15;
        c0 = consumed;
        in_q.push_back(4'h9);
        @(posedge clk);
        #1 num_syms = 16'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("bad_err", 32'(err), 1);
        check("bad_busy", 32'(busy), 0);
        check("bad_in_rdy", 32'(in_rdy), 0);
        @(negedge clk);
        check("bad_err_pulse", 32'(err), 0);
        set_uniform();
        do_start(16'd0);
        @(negedge clk);
        check("zero_done", 32'(done), 1);
        check("zero_busy", 32'(busy), 0);
        @(negedge clk);
        check("zero_done_pulse", 32'(done), 0);
        check("zero_consumed", consumed - c0, 0);
        in_q.delete();

        // Asynchronous reset while waiting in RENORM.
        c0 = consumed;
        in_q.push_back(4'h1);
        in_q.push_back(4'h2);
        in_q.push_back(4'h3);
        in_q.push_back(4'h4);
        exp_q.push_back(4'd3);
        do_start(16'd2);
        k = 0;
        while (!(in_rdy && consumed - c0 == 4 && exp_q.size() == 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rn_reached", 32'(in_rdy), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rn_rst_in_rdy", 32'(in_rdy), 0);
        check("rn_rst_out_vld", 32'(out_vld), 0);
        check("rn_rst_out", 32'(out_w), 0);
        check("rn_rst_busy", 32'(busy), 0);
        check("rn_rst_done", 32'(done), 0);
        check("rn_rst_err", 32'(err), 0);
        in_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        vec1("post_rst");

        check("protocol", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
